pe_scheduler: RTL

Sequencer for a single PE over one layer tile. Walks output positions (row, col) and weight groups, fetches the IA bundle and W bundle for each job via request/valid handshakes, pulses the PE start, waits for finish, then hands the result to the output writer under backpressure. IA is fetched once per position and reused across all weight groups. A watchdog aborts the layer if the PE hangs.

---
 rtl/pe_scheduler.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/pe_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pe_scheduler
// Description : Sequencer for one PE over a layer tile. Walks output positions
//               (row, col) and weight groups, fetching IA once per position
//               and W once per job, launching the PE, waiting for finish
//               under a watchdog and handing each result to the output writer.
// Ports       : i_clk/i_rst              clock, async active-high reset
//               i_start, i_num_*         layer start and geometry (latched)
//               o_busy/o_done/o_timeout  layer status
//               o_ia_req/i_ia_valid      IA fetch handshake, o_ia_row/col tag
//               o_w_req/i_w_valid        W fetch handshake, o_w_grp tag
//               o_pe_start/i_pe_finish   PE control, o_pe_h/o_pe_w position
//               o_out_valid/i_out_ready  result hand-off, o_out_* tags
// Revision    : 1.0  initial release
// ============================================================================
module pe_scheduler #(
    parameter int MAX_ROW = 32,
    parameter int MAX_COL = 32,
    parameter int MAX_GRP = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_start,
    input  logic [$clog2(MAX_ROW):0]   i_num_rows,
    input  logic [$clog2(MAX_COL):0]   i_num_cols,
    input  logic [$clog2(MAX_GRP):0]   i_num_grps,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_timeout,
    output logic                       o_ia_req,
    output logic [$clog2(MAX_ROW)-1:0] o_ia_row,
    output logic [$clog2(MAX_COL)-1:0] o_ia_col,
    input  logic                       i_ia_valid,
    output logic                       o_w_req,
    output logic [$clog2(MAX_GRP)-1:0] o_w_grp,
    input  logic                       i_w_valid,
    output logic                       o_pe_start,
    output logic [$clog2(MAX_ROW)-1:0] o_pe_h,
    output logic [$clog2(MAX_COL)-1:0] o_pe_w,
    input  logic                       i_pe_finish,
    output logic                       o_out_valid,
    output logic [$clog2(MAX_ROW)-1:0] o_out_row,
    output logic [$clog2(MAX_COL)-1:0] o_out_col,
    output logic [$clog2(MAX_GRP)-1:0] o_out_grp,
    input  logic                       i_out_ready
);

    localparam int c_RW  = $clog2(MAX_ROW);
    localparam int c_CW  = $clog2(MAX_COL);
    localparam int c_GW  = $clog2(MAX_GRP);
    localparam int c_WDW = $clog2(TIMEOUT + 1);
    // Watchdog value seen in the last permitted WAIT cycle.
    localparam logic [c_WDW-1:0] c_WD_LAST = c_WDW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_DRAIN  = 3'd4,
        S_NEXT   = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [c_RW:0]    r_num_rows, w_num_rows_nxt;
    logic [c_CW:0]    r_num_cols, w_num_cols_nxt;
    logic [c_GW:0]    r_num_grps, w_num_grps_nxt;
    logic [c_RW-1:0]  r_row, w_row_nxt;
    logic [c_CW-1:0]  r_col, w_col_nxt;
    logic [c_GW-1:0]  r_grp, w_grp_nxt;
    logic [c_WDW-1:0] r_wd, w_wd_nxt;
    logic             r_ia_req, w_ia_req_nxt;
    logic             r_w_req, w_w_req_nxt;
    logic             r_ia_sat, w_ia_sat_nxt;
    logic             r_w_sat, w_w_sat_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic             r_busy, r_done, r_pe_start, r_out_valid;
    logic             w_ia_ok, w_w_ok, w_fetch_enter;
    logic             w_row_last, w_col_last, w_grp_last;

    assign w_row_last = ({1'b0, r_row} + (c_RW + 1)'(1)) == r_num_rows;
    assign w_col_last = ({1'b0, r_col} + (c_CW + 1)'(1)) == r_num_cols;
    assign w_grp_last = ({1'b0, r_grp} + (c_GW + 1)'(1)) == r_num_grps;

    always_comb begin
        w_state_nxt    = r_state;
        w_num_rows_nxt = r_num_rows;
        w_num_cols_nxt = r_num_cols;
        w_num_grps_nxt = r_num_grps;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_grp_nxt      = r_grp;
        w_wd_nxt       = r_wd;
        w_ia_req_nxt   = 1'b0;
        w_w_req_nxt    = 1'b0;
        w_ia_sat_nxt   = r_ia_sat;
        w_w_sat_nxt    = r_w_sat;
        w_timeout_nxt  = r_timeout;
        w_fetch_enter  = 1'b0;
        // A side counts as satisfied if already done, or if its valid is
        // sampled while its own request is up (valid with req low is ignored).
        w_ia_ok        = r_ia_sat | (r_ia_req & i_ia_valid);
        w_w_ok         = r_w_sat | (r_w_req & i_w_valid);

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_num_rows_nxt = i_num_rows;
                    w_num_cols_nxt = i_num_cols;
                    w_num_grps_nxt = i_num_grps;
                    w_timeout_nxt  = 1'b0;
                    w_row_nxt      = '0;
                    w_col_nxt      = '0;
                    w_grp_nxt      = '0;
                    if (i_num_rows == '0 || i_num_cols == '0 || i_num_grps == '0) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_state_nxt   = S_FETCH;
                        w_fetch_enter = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (w_ia_ok && w_w_ok) begin
                    w_state_nxt = S_LAUNCH;
                end else begin
                    w_ia_req_nxt = r_ia_req & ~i_ia_valid;
                    w_w_req_nxt  = r_w_req & ~i_w_valid;
                    w_ia_sat_nxt = w_ia_ok;
                    w_w_sat_nxt  = w_w_ok;
                end
            end
            S_LAUNCH: begin
                w_wd_nxt    = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Finish is checked first so it beats a same-cycle timeout.
                if (i_pe_finish) begin
                    w_state_nxt = S_DRAIN;
                end else if (r_wd == c_WD_LAST) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else begin
                    w_wd_nxt = r_wd + c_WDW'(1);
                end
            end
            S_DRAIN: begin
                if (i_out_ready) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT: begin
                w_state_nxt   = S_FETCH;
                w_fetch_enter = 1'b1;
                if (!w_grp_last) begin
                    w_grp_nxt = r_grp + c_GW'(1);
                end else begin
                    w_grp_nxt = '0;
                    if (!w_col_last) begin
                        w_col_nxt = r_col + c_CW'(1);
                    end else begin
                        w_col_nxt = '0;
                        if (!w_row_last) begin
                            w_row_nxt = r_row + c_RW'(1);
                        end else begin
                            w_state_nxt   = S_DONE;
                            w_fetch_enter = 1'b0;
                        end
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // IA is only fetched at the first weight group of a position; for
        // later groups the IA side starts out already satisfied.
        if (w_fetch_enter) begin
            w_ia_req_nxt = (w_grp_nxt == '0);
            w_ia_sat_nxt = (w_grp_nxt != '0);
            w_w_req_nxt  = 1'b1;
            w_w_sat_nxt  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_num_rows  <= '0;
            r_num_cols  <= '0;
            r_num_grps  <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_grp       <= '0;
            r_wd        <= '0;
            r_ia_req    <= 1'b0;
            r_w_req     <= 1'b0;
            r_ia_sat    <= 1'b0;
            r_w_sat     <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pe_start  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_num_rows  <= w_num_rows_nxt;
            r_num_cols  <= w_num_cols_nxt;
            r_num_grps  <= w_num_grps_nxt;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_grp       <= w_grp_nxt;
            r_wd        <= w_wd_nxt;
            r_ia_req    <= w_ia_req_nxt;
            r_w_req     <= w_w_req_nxt;
            r_ia_sat    <= w_ia_sat_nxt;
            r_w_sat     <= w_w_sat_nxt;
            r_timeout   <= w_timeout_nxt;
            // Status strobes are registered from the next state so they line
            // up exactly with the state they describe.
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_pe_start  <= (w_state_nxt == S_LAUNCH);
            r_out_valid <= (w_state_nxt == S_DRAIN);
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_timeout   = r_timeout;
    assign o_ia_req    = r_ia_req;
    assign o_ia_row    = r_row;
    assign o_ia_col    = r_col;
    assign o_w_req     = r_w_req;
    assign o_w_grp     = r_grp;
    assign o_pe_start  = r_pe_start;
    assign o_pe_h      = r_row;
    assign o_pe_w      = r_col;
    assign o_out_valid = r_out_valid;
    assign o_out_row   = r_row;
    assign o_out_col   = r_col;
    assign o_out_grp   = r_grp;

endmodule
`default_nettype wire
